// File: rtl/cu_imm_encoder_if.sv
// rtl/cu_imm_encoder_if.sv - handshake and status bundle for cu_imm_encoder
interface cu_imm_encoder_if #(
    parameter int ADDR_W = 8,
    parameter int ERR_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_imm_src;
    logic [15:0]       in_base;
    logic [15:0]       in_imm;
    logic              addr_clr;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              err_pulse;
    logic [ERR_W-1:0]  err_count;

    modport slave (
        input  in_valid, in_imm_src, in_base, in_imm, addr_clr, out_ready,
        output in_ready, out_valid, out_instr, out_addr, err_pulse, err_count
    );

    modport master (
        output in_valid, in_imm_src, in_base, in_imm, addr_clr, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, err_pulse, err_count
    );
endinterface

// File: rtl/cu_imm_encoder.sv
// rtl/cu_imm_encoder.sv - immediate encoder with output register + skid; optional range check under CU_IMM_RANGE_CHECK_EN
module cu_imm_encoder #(
    parameter int ADDR_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    cu_imm_encoder_if.slave   bus
);
    logic              w_accept;
    logic              w_legal;
    logic              w_push;
    logic              w_load_out;
    logic [15:0]       w_enc;
    logic [ADDR_W-1:0] w_tag;
    logic              w_unused;

    logic              r_out_valid;
    logic [15:0]       r_out_instr;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_skid_valid;
    logic [15:0]       r_skid_instr;
    logic [ADDR_W-1:0] r_skid_addr;
    logic [ADDR_W-1:0] r_addr_cnt;

    assign w_accept   = bus.in_valid && !r_skid_valid;
    assign w_push     = w_accept && w_legal;
    assign w_load_out = !r_out_valid || bus.out_ready;
    // A clear that coincides with an accept tags that word with address 0
    assign w_tag      = bus.addr_clr ? '0 : r_addr_cnt;
    assign w_unused   = &{1'b0, bus.in_imm[15:11]};

    always_comb begin
        w_enc = bus.in_base;
        case (bus.in_imm_src)
            2'b00, 2'b01: begin
                w_enc[4:2]  = bus.in_imm[2:0];
                w_enc[12:8] = bus.in_imm[7:3];
            end
            2'b11: begin
                w_enc[4:2]  = bus.in_imm[2:0];
                w_enc[7:5]  = bus.in_imm[10:8];
                w_enc[12:8] = bus.in_imm[7:3];
            end
            default: w_enc = bus.in_base;
        endcase
    end

`ifdef CU_IMM_RANGE_CHECK_EN
    logic             r_err_pulse;
    logic [ERR_W-1:0] r_err_count;

    always_comb begin
        case (bus.in_imm_src)
            2'b00:   w_legal = (bus.in_imm[15:7] == 9'h000) || (bus.in_imm[15:7] == 9'h1FF);
            2'b01:   w_legal = (bus.in_imm[15:8] == 8'h00);
            2'b11:   w_legal = (bus.in_imm[15:11] == 5'h00);
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err_pulse <= w_accept && !w_legal;
            if (w_accept && !w_legal && (r_err_count != '1)) begin
                r_err_count <= r_err_count + ERR_W'(1);
            end
        end
    end

    assign bus.err_pulse = r_err_pulse;
    assign bus.err_count = r_err_count;
`else
    assign w_legal       = 1'b1;
    assign bus.err_pulse = 1'b0;
    assign bus.err_count = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_instr  <= '0;
            r_out_addr   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= '0;
            r_skid_addr  <= '0;
            r_addr_cnt   <= '0;
        end else begin
            if (w_push) begin
                r_addr_cnt <= w_tag + ADDR_W'(1);
            end else if (bus.addr_clr) begin
                r_addr_cnt <= '0;
            end

            // Skid is only ever full while in_ready is low, so it never collides with a push
            if (w_load_out) begin
                if (r_skid_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_instr  <= r_skid_instr;
                    r_out_addr   <= r_skid_addr;
                    r_skid_valid <= 1'b0;
                end else if (w_push) begin
                    r_out_valid <= 1'b1;
                    r_out_instr <= w_enc;
                    r_out_addr  <= w_tag;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_push) begin
                r_skid_valid <= 1'b1;
                r_skid_instr <= w_enc;
                r_skid_addr  <= w_tag;
            end
        end
    end

    assign bus.in_ready  = !r_skid_valid;
    assign bus.out_valid = r_out_valid;
    assign bus.out_instr = r_out_instr;
    assign bus.out_addr  = r_out_addr;
endmodule
